axi_mem_sched: RTL and testbench
================================

AXI_MEM_SCHED -- requirements
Module: axi_mem_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of the request and memory address ports.
REQ-002 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed write priority.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 wr_req/rd_req  in  1  burst request from the write/read channel front end (held until grant).
REQ-006 wr_addr/rd_addr  in  ADDR_W  burst start address (AxADDR).
REQ-007 wr_len/rd_len  in  8  beats minus one (AxLEN).
REQ-008 wr_size/rd_size  in  3  bytes per beat = 2^size (AxSIZE).
REQ-009 wr_burst/rd_burst  in  2  burst type (00 FIXED, 01 INCR, 10 WRAP, 11 reserved).
REQ-010 wr_gnt/rd_gnt  out  1  one-cycle grant pulse.
REQ-011 wr_beat_valid  in  1  write data beat available this cycle (W channel handshake).
REQ-012 rd_beat_ready  in  1  read return path can take a beat this cycle.
REQ-013 mem_en  out  1  memory access this cycle; mem_we  out  1  access is a write.
REQ-014 mem_addr  out  ADDR_W  address of current beat; beat_last  out  1  current access is final beat.
REQ-015 busy  out  1  a burst is in progress.

Function
REQ-016 FSM states IDLE, WR_BURST, RD_BURST; exactly one burst owns the memory at a time.
REQ-017 IDLE: arbitration is evaluated every cycle; on a win, request fields are latched and the FSM enters the burst state at the next edge.
REQ-018 Only wr_req -> write wins; only rd_req -> read wins; both -> with RR_EN=1 the side not granted last wins; with RR_EN=0 write wins.
REQ-019 wr_gnt/rd_gnt SHALL be registered and high for exactly the first cycle in WR_BURST/RD_BURST; the requester drops req on seeing gnt.
REQ-020 WR_BURST: mem_en=mem_we=1 combinationally in each cycle with wr_beat_valid=1; no access otherwise (stall, address held).
REQ-021 RD_BURST: mem_en=1, mem_we=0 in each cycle with rd_beat_ready=1; stall otherwise.
REQ-022 Beat counter increments per access; beat_last=1 when the count equals the latched len, gated by mem_en.
REQ-023 After the last access, FSM returns to IDLE; IDLE lasts at least one cycle between bursts.
REQ-024 len=0 is a single-beat burst; len=255 is 256 beats; the counter SHALL NOT wrap.
REQ-025 Effective size = min(size,2); sizes 3-7 are treated as 2 (32-bit data path).
REQ-026 FIXED: mem_addr constant for all beats.
REQ-027 INCR: next = addr + 2^size, modulo 2^ADDR_W; 4 KB crossing is not checked.
REQ-028 WRAP: total = 2^size*(len+1); boundary = addr aligned down to total; when addr+2^size reaches boundary+total, next = boundary.
REQ-029 WRAP with len not in {1,3,7,15}, and burst 11, SHALL be treated as INCR.
REQ-030 busy=1 in WR_BURST and RD_BURST, 0 in IDLE.
REQ-031 req changes during a burst SHALL NOT affect the active burst.

Reset
REQ-032 RST=1 at an edge forces IDLE from any state, including mid-burst; the partial burst is abandoned.
REQ-033 Reset values: mem_en, mem_we, beat_last, wr_gnt, rd_gnt, busy = 0; mem_addr = 0; beat counter = 0.
REQ-034 Last-granted flag resets to "read", so write wins the first contested arbitration.

Structure
REQ-035 Shared package axi_mem_sched_pkg SHALL hold the burst-type enum (FIXED/INCR/WRAP/RSVD), the FSM state enum and the data-width constant (4 bytes).
REQ-036 Next-address logic SHALL be a separate combinational sub-module axi_addr_gen (inputs addr, size, len, burst; output next_addr).

Verification
REQ-037 Write INCR addr 0x100, len 3, size 2, wr_beat_valid always 1 -> wr_gnt one cycle; mem_we accesses at 0x100, 0x104, 0x108, 0x10C; beat_last on 0x10C.
REQ-038 Read WRAP addr 0x38, len 3, size 2 -> addresses 0x38, 0x3C, 0x30, 0x34; beat_last on 0x34.
REQ-039 wr_req and rd_req asserted together, held across 3 rounds after reset -> grant order W, R, W; with RR_EN=0 -> W, W, W.
REQ-040 Read FIXED addr 0x20, len 2, rd_beat_ready toggling 1,0,1,0,1 -> three accesses at 0x20, no access in stall cycles.
REQ-041 RST asserted on 2nd beat of an 8-beat write -> next cycle busy=0, mem_en=0, mem_addr=0; next contested request granted to write.
REQ-042 INCR addr 0xFFFFFFFC, len 1, size 2 -> addresses 0xFFFFFFFC, 0x00000000; size 3 request at 0x0 behaves as size 2.

Source files
------------

// File: rtl/axi_mem_sched_pkg.sv
// Shared types and constants for the AXI burst memory scheduler.
package axi_mem_sched_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    localparam int DATA_BYTES = 4;
    localparam int MAX_SIZE   = $clog2(DATA_BYTES);

    // Beats wider than the data path are narrowed to the full data width.
    function automatic logic [1:0] eff_size(input logic [2:0] size);
        return (size > 3'(MAX_SIZE)) ? 2'(MAX_SIZE) : size[1:0];
    endfunction

endpackage

// File: rtl/axi_mem_sched_if.sv
// Request/grant and memory-access bundle between the channel front ends and the scheduler.
interface axi_mem_sched_if #(
    parameter int ADDR_W = 32
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        wr_len;
    logic [7:0]        rd_len;
    logic [2:0]        wr_size;
    logic [2:0]        rd_size;
    logic [1:0]        wr_burst;
    logic [1:0]        rd_burst;
    logic              wr_gnt;
    logic              rd_gnt;
    logic              wr_beat_valid;
    logic              rd_beat_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              beat_last;
    logic              busy;

    modport slave (
        input  wr_req, rd_req, wr_addr, rd_addr, wr_len, rd_len,
               wr_size, rd_size, wr_burst, rd_burst,
               wr_beat_valid, rd_beat_ready,
        output wr_gnt, rd_gnt, mem_en, mem_we, mem_addr, beat_last, busy
    );

    modport master (
        output wr_req, rd_req, wr_addr, rd_addr, wr_len, rd_len,
               wr_size, rd_size, wr_burst, rd_burst,
               wr_beat_valid, rd_beat_ready,
        input  wr_gnt, rd_gnt, mem_en, mem_we, mem_addr, beat_last, busy
    );

endinterface

// File: rtl/axi_addr_gen.sv
// Combinational AXI next-beat address: FIXED, INCR and WRAP bursts.
module axi_addr_gen
    import axi_mem_sched_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  burst_t            burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [1:0]        esz;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] boundary;
    logic              wrap_ok;

    always_comb begin
        esz      = eff_size(size);
        incr     = ADDR_W'(1) << esz;
        seq_addr = addr + incr;
        // Illegal wrap lengths fall back to incrementing, as does the reserved type.
        wrap_ok  = (burst == BURST_WRAP) &&
                   (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        total    = ADDR_W'({1'b0, len} + 9'd1) << esz;
        boundary = addr & ~(total - ADDR_W'(1));

        next_addr = seq_addr;
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (wrap_ok && (seq_addr == boundary + total))
            next_addr = boundary;
    end

endmodule

// File: rtl/axi_mem_sched.sv
// Arbitrates write/read burst requests onto a single memory port, one beat per accepted cycle.
module axi_mem_sched
    import axi_mem_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RR_EN  = 1
) (
    input logic             CLK,
    input logic             RST,
    axi_mem_sched_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    burst_t            burst_q;
    logic              last_wr_q;
    logic              wr_gnt_q;
    logic              rd_gnt_q;
    logic              pick_wr;
    logic              pick_rd;
    logic              access;
    logic              last_beat;

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Arbitration: on contention the side not granted last wins, unless fixed priority.
    always_comb begin
        pick_wr = 1'b0;
        pick_rd = 1'b0;
        if (state_q == IDLE) begin
            if (bus.wr_req && (!bus.rd_req || RR_EN == 0 || !last_wr_q))
                pick_wr = 1'b1;
            else if (bus.rd_req)
                pick_rd = 1'b1;
        end
    end

    always_comb begin
        access    = ((state_q == WR_BURST) && bus.wr_beat_valid) ||
                    ((state_q == RD_BURST) && bus.rd_beat_ready);
        last_beat = access && (cnt_q == len_q);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_wr)      state_d = WR_BURST;
                else if (pick_rd) state_d = RD_BURST;
            end
            WR_BURST, RD_BURST: begin
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= '0;
            last_wr_q <= 1'b0;
            wr_gnt_q  <= 1'b0;
            rd_gnt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_gnt_q <= pick_wr;
            rd_gnt_q <= pick_rd;
            if (pick_wr) begin
                last_wr_q <= 1'b1;
                addr_q    <= bus.wr_addr;
                len_q     <= bus.wr_len;
                size_q    <= bus.wr_size;
                burst_q   <= burst_t'(bus.wr_burst);
                cnt_q     <= '0;
            end else if (pick_rd) begin
                last_wr_q <= 1'b0;
                addr_q    <= bus.rd_addr;
                len_q     <= bus.rd_len;
                size_q    <= bus.rd_size;
                burst_q   <= burst_t'(bus.rd_burst);
                cnt_q     <= '0;
            end else if (access) begin
                // Counter parks at zero after the final beat so len=255 never wraps mid-burst.
                addr_q <= next_addr;
                cnt_q  <= last_beat ? 8'd0 : cnt_q + 8'd1;
            end
        end
    end

    assign bus.wr_gnt    = wr_gnt_q;
    assign bus.rd_gnt    = rd_gnt_q;
    assign bus.mem_en    = access;
    assign bus.mem_we    = access && (state_q == WR_BURST);
    assign bus.mem_addr  = addr_q;
    assign bus.beat_last = last_beat;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_mem_sched.sv
// Scoreboard bench for axi_mem_sched: round-robin instance fully checked, fixed-priority instance for grant order.
module tb_axi_mem_sched;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    axi_mem_sched_if #(.ADDR_W(32)) bus0 ();
    axi_mem_sched_if #(.ADDR_W(32)) bus1 ();

    axi_mem_sched #(.ADDR_W(32), .RR_EN(1)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    axi_mem_sched #(.ADDR_W(32), .RR_EN(0)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic        last;
    } acc_t;

    acc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;

    // Scoreboard: every memory access on dut0 must match the next expected beat.
    always @(negedge CLK) begin
        if (bus0.mem_en) begin
            acc_t e;
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access got we=%0b addr=%h last=%0b, required no access",
                         bus0.mem_we, bus0.mem_addr, bus0.beat_last);
            end else begin
                e = exp_q.pop_front();
                if ({bus0.mem_we, bus0.mem_addr, bus0.beat_last} !== {e.we, e.addr, e.last})
                begin
                    errors++;
                    $display("FAIL access got we=%0b addr=%h last=%0b, required we=%0b addr=%h last=%0b",
                             bus0.mem_we, bus0.mem_addr, bus0.beat_last, e.we, e.addr, e.last);
                end
            end
        end
    end

    task automatic push_exp(input logic we, input logic [31:0] addr, input logic last);
        acc_t e;
        e.we = we; e.addr = addr; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic start_burst(input bit is_wr, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        if (is_wr) begin
            bus0.wr_addr = addr; bus0.wr_len = len; bus0.wr_size = size; bus0.wr_burst = burst;
            bus0.wr_req = 1'b1;
        end else begin
            bus0.rd_addr = addr; bus0.rd_len = len; bus0.rd_size = size; bus0.rd_burst = burst;
            bus0.rd_req = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (is_wr ? bus0.wr_gnt : bus0.rd_gnt) ok = 1;
        end
        bus0.wr_req = 1'b0;
        bus0.rd_req = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL grant_timeout got no grant, required grant within 20 cycles");
        end
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !bus0.busy) done = 1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got %0d beats outstanding busy=%0b, required 0 and idle",
                     name, exp_q.size(), bus0.busy);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks += 6;
        if (bus0.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b, required 0", bus0.busy); end
        if (bus0.mem_en !== 1'b0)    begin errors++; $display("FAIL rst_mem_en got %0b, required 0", bus0.mem_en); end
        if (bus0.mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we got %0b, required 0", bus0.mem_we); end
        if (bus0.beat_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b, required 0", bus0.beat_last); end
        if ({bus0.wr_gnt, bus0.rd_gnt} !== 2'b00)
            begin errors++; $display("FAIL rst_gnt got %b, required 00", {bus0.wr_gnt, bus0.rd_gnt}); end
        if (bus0.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h, required 0", bus0.mem_addr); end
        RST = 1'b0;
    endtask

    task automatic test_contested();
        logic [2:0] ord0 = '0, ord1 = '0;
        int n0 = 0, n1 = 0;
        bus0.wr_addr = 32'h40; bus0.wr_len = 8'd0; bus0.wr_size = 3'd2; bus0.wr_burst = 2'b01;
        bus0.rd_addr = 32'h80; bus0.rd_len = 8'd0; bus0.rd_size = 3'd2; bus0.rd_burst = 2'b01;
        bus1.wr_addr = 32'h40; bus1.wr_len = 8'd0; bus1.wr_size = 3'd2; bus1.wr_burst = 2'b01;
        bus1.rd_addr = 32'h80; bus1.rd_len = 8'd0; bus1.rd_size = 3'd2; bus1.rd_burst = 2'b01;
        push_exp(1'b1, 32'h40, 1'b1);
        push_exp(1'b0, 32'h80, 1'b1);
        push_exp(1'b1, 32'h40, 1'b1);
        bus0.wr_req = 1'b1; bus0.rd_req = 1'b1;
        bus1.wr_req = 1'b1; bus1.rd_req = 1'b1;
        for (int c = 0; c < 60 && (n0 < 3 || n1 < 3); c++) begin
            @(negedge CLK);
            if (n0 < 3 && (bus0.wr_gnt || bus0.rd_gnt)) begin
                ord0[n0] = bus0.wr_gnt;
                n0++;
                if (n0 == 3) begin bus0.wr_req = 1'b0; bus0.rd_req = 1'b0; end
            end
            if (n1 < 3 && (bus1.wr_gnt || bus1.rd_gnt)) begin
                ord1[n1] = bus1.wr_gnt;
                n1++;
                if (n1 == 3) begin bus1.wr_req = 1'b0; bus1.rd_req = 1'b0; end
            end
        end
        bus0.wr_req = 1'b0; bus0.rd_req = 1'b0;
        bus1.wr_req = 1'b0; bus1.rd_req = 1'b0;
        checks += 2;
        if (n0 !== 3 || ord0 !== 3'b101) begin
            errors++;
            $display("FAIL rr_order got %0d grants order=%b, required 3 grants order=101 (W,R,W)", n0, ord0);
        end
        if (n1 !== 3 || ord1 !== 3'b111) begin
            errors++;
            $display("FAIL fixed_order got %0d grants order=%b, required 3 grants order=111 (W,W,W)", n1, ord1);
        end
        wait_done("contested");
    endtask

    task automatic test_write_incr();
        push_exp(1'b1, 32'h100, 1'b0);
        push_exp(1'b1, 32'h104, 1'b0);
        push_exp(1'b1, 32'h108, 1'b0);
        push_exp(1'b1, 32'h10C, 1'b1);
        start_burst(1'b1, 32'h100, 8'd3, 3'd2, 2'b01);
        checks++;
        if (bus0.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b, required 1", bus0.busy); end
        @(negedge CLK);
        checks++;
        if (bus0.wr_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_pulse got %0b, required 0", bus0.wr_gnt); end
        wait_done("write_incr");
    endtask

    task automatic test_read_wrap();
        push_exp(1'b0, 32'h38, 1'b0);
        push_exp(1'b0, 32'h3C, 1'b0);
        push_exp(1'b0, 32'h30, 1'b0);
        push_exp(1'b0, 32'h34, 1'b1);
        start_burst(1'b0, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_done("read_wrap");
    endtask

    task automatic test_read_fixed_stall();
        logic [3:0] pat = 4'b1010;
        int start_cnt = acc_cnt;
        push_exp(1'b0, 32'h20, 1'b0);
        push_exp(1'b0, 32'h20, 1'b0);
        push_exp(1'b0, 32'h20, 1'b1);
        start_burst(1'b0, 32'h20, 8'd2, 3'd2, 2'b00);
        for (int i = 3; i >= 0; i--) begin
            @(posedge CLK);
            #1 bus0.rd_beat_ready = pat[i];
            @(negedge CLK);
            if (pat[i] == 1'b0) begin
                checks++;
                if (bus0.mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_access got mem_en=%0b, required 0", bus0.mem_en);
                end
            end
        end
        @(posedge CLK);
        #1 bus0.rd_beat_ready = 1'b1;
        wait_done("read_fixed");
        checks++;
        if (acc_cnt - start_cnt !== 3) begin
            errors++;
            $display("FAIL fixed_count got %0d accesses, required 3", acc_cnt - start_cnt);
        end
    endtask

    task automatic test_incr_rollover();
        push_exp(1'b1, 32'hFFFF_FFFC, 1'b0);
        push_exp(1'b1, 32'h0000_0000, 1'b1);
        start_burst(1'b1, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
        wait_done("rollover");
    endtask

    task automatic test_size_clamp();
        push_exp(1'b0, 32'h0, 1'b0);
        push_exp(1'b0, 32'h4, 1'b1);
        start_burst(1'b0, 32'h0, 8'd1, 3'd3, 2'b01);
        wait_done("size3");
    endtask

    task automatic test_reset_mid_burst();
        push_exp(1'b1, 32'h200, 1'b0);
        push_exp(1'b1, 32'h204, 1'b0);
        start_burst(1'b1, 32'h200, 8'd7, 3'd2, 2'b01);
        @(negedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        checks += 4;
        if (bus0.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %0b, required 0", bus0.busy); end
        if (bus0.mem_en !== 1'b0)    begin errors++; $display("FAIL midrst_mem_en got %0b, required 0", bus0.mem_en); end
        if (bus0.mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h, required 0", bus0.mem_addr); end
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_beats got %0d beats unseen, required 0", exp_q.size());
        end
        exp_q.delete();
        RST = 1'b0;
        // Previous grant was a write; reset must hand the next contest back to write.
        bus0.rd_addr = 32'h380; bus0.rd_len = 8'd0; bus0.rd_size = 3'd2; bus0.rd_burst = 2'b01;
        push_exp(1'b1, 32'h300, 1'b1);
        bus0.rd_req = 1'b1;
        start_burst(1'b1, 32'h300, 8'd0, 3'd2, 2'b01);
        checks++;
        if (bus0.rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_contest got rd_gnt=1, required write granted");
        end
        wait_done("post_reset");
    endtask

    initial begin
        bus0.wr_req = 0; bus0.rd_req = 0; bus1.wr_req = 0; bus1.rd_req = 0;
        bus0.wr_addr = 0; bus0.rd_addr = 0; bus1.wr_addr = 0; bus1.rd_addr = 0;
        bus0.wr_len = 0; bus0.rd_len = 0; bus1.wr_len = 0; bus1.rd_len = 0;
        bus0.wr_size = 0; bus0.rd_size = 0; bus1.wr_size = 0; bus1.rd_size = 0;
        bus0.wr_burst = 0; bus0.rd_burst = 0; bus1.wr_burst = 0; bus1.rd_burst = 0;
        bus0.wr_beat_valid = 1; bus0.rd_beat_ready = 1;
        bus1.wr_beat_valid = 1; bus1.rd_beat_ready = 1;

        test_reset();
        test_contested();
        test_write_incr();
        test_read_wrap();
        test_read_fixed_stall();
        test_incr_rollover();
        test_size_clamp();
        test_reset_mid_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
